// File: rtl/memory_protection_mr_pkg.sv
// Shared types and helpers for the multi-region memory protection monitor.
package memory_protection_mr_pkg;

  localparam int MP_MAX_REGIONS = 8;
  localparam int MP_REGION_W    = 3;
  localparam int MP_COUNT_W     = 8;

  // Monitor FSM: core held in reset (KILL), waiting for the handler (WAIT), free running (RUN).
  typedef enum logic [1:0] {
    MP_KILL = 2'd0,
    MP_WAIT = 2'd1,
    MP_RUN  = 2'd2
  } mp_state_e;

  // Origin of a violating access.
  typedef enum logic {
    MP_SRC_CPU = 1'b0,
    MP_SRC_DMA = 1'b1
  } mp_src_e;

  // Saturating increment for the violation counter.
  function automatic logic [MP_COUNT_W-1:0] mp_sat_inc(input logic [MP_COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/memory_protection_mr_if.sv
// Core bus taps into the monitor plus the monitor's reset request and fault record.
interface memory_protection_mr_if #(
  parameter int ADDR_W = 16
);
  import memory_protection_mr_pkg::*;

  logic [ADDR_W-1:0]      pc;
  logic [ADDR_W-1:0]      data_addr;
  logic                   w_en;
  logic [ADDR_W-1:0]      dma_addr;
  logic                   dma_en;

  logic                   reset;
  logic                   viol_valid;
  logic [MP_REGION_W-1:0] viol_region;
  logic                   viol_src;
  logic [ADDR_W-1:0]      viol_addr;
  logic [MP_COUNT_W-1:0]  viol_count;

  // Core side: presents bus activity, observes the reset request.
  modport master (
    output pc, data_addr, w_en, dma_addr, dma_en,
    input  reset, viol_valid, viol_region, viol_src, viol_addr, viol_count
  );

  // Monitor side.
  modport slave (
    input  pc, data_addr, w_en, dma_addr, dma_en,
    output reset, viol_valid, viol_region, viol_src, viol_addr, viol_count
  );

endinterface

// File: rtl/memory_protection_mr_region_check.sv
// Combinational access check for one protected region and its trusted code window.
module memory_protection_mr_region_check #(
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE     = '0,
  parameter logic [ADDR_W-1:0] SIZE     = '0,
  parameter logic [ADDR_W-1:0] TCB_BASE = '0,
  parameter logic [ADDR_W-1:0] TCB_SIZE = '0,
  parameter bit              DMA_ALLOW = 1'b0
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_en,
  output logic              cpu_viol,
  output logic              dma_viol
);

  // One extra bit so a region ending exactly at the top of the address space does not wrap.
  localparam logic [ADDR_W:0] REGION_LO = {1'b0, BASE};
  localparam logic [ADDR_W:0] REGION_HI = {1'b0, BASE} + {1'b0, SIZE};

  // The last trusted pc is tcb_base+tcb_size-2; testing pc+2 <= tcb_base+tcb_size
  // is the same bound without the underflow a tiny tcb_size would cause.
  localparam logic [ADDR_W+1:0] TCB_LIMIT = {2'b00, TCB_BASE} + {2'b00, TCB_SIZE};
  localparam bit                TCB_EN    = (TCB_SIZE != '0);

  logic data_hit;
  logic dma_hit;
  logic pc_in_tcb;

  // A zero-sized region gives REGION_HI == REGION_LO, so it never hits.
  always_comb begin
    data_hit  = ({1'b0, data_addr} >= REGION_LO) && ({1'b0, data_addr} < REGION_HI);
    dma_hit   = ({1'b0, dma_addr}  >= REGION_LO) && ({1'b0, dma_addr}  < REGION_HI);
    pc_in_tcb = TCB_EN && (pc >= TCB_BASE) && (({2'b00, pc} + (ADDR_W+2)'(2)) <= TCB_LIMIT);
    cpu_viol  = w_en && data_hit && !pc_in_tcb;
    dma_viol  = dma_en && dma_hit && !DMA_ALLOW;
  end

endmodule

// File: rtl/memory_protection_mr.sv
// Multi-region write/DMA monitor: any violation forces the core into reset,
// holds it for a minimum pulse, then until pc reaches the reset handler.
module memory_protection_mr
  import memory_protection_mr_pkg::*;
#(
  parameter int                          ADDR_W        = 16,
  parameter int                          N_REGIONS     = 4,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE   = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_SIZE   = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] TCB_BASE      = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] TCB_SIZE      = '0,
  parameter logic [N_REGIONS-1:0]        DMA_ALLOW     = '0,
  parameter logic [ADDR_W-1:0]           RESET_HANDLER = '0,
  parameter int                          RST_HOLD      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  memory_protection_mr_if.slave bus
);

  localparam int                HOLD_W      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RST_HOLD - 1);

  logic [N_REGIONS-1:0] cpu_viol;
  logic [N_REGIONS-1:0] dma_viol;
  logic                 any_viol;

  logic [MP_REGION_W-1:0] win_region;
  mp_src_e                win_src;
  logic [ADDR_W-1:0]      win_addr;

  mp_state_e              state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   reset_q;
  logic                   viol_valid_q;
  logic [MP_REGION_W-1:0] viol_region_q;
  mp_src_e                viol_src_q;
  logic [ADDR_W-1:0]      viol_addr_q;
  logic [MP_COUNT_W-1:0]  viol_count_q;

  // Overlapping regions are checked independently; each gets its own checker.
  for (genvar i = 0; i < N_REGIONS; i++) begin : g_region
    memory_protection_mr_region_check #(
      .ADDR_W    (ADDR_W),
      .BASE      (REGION_BASE[i*ADDR_W +: ADDR_W]),
      .SIZE      (REGION_SIZE[i*ADDR_W +: ADDR_W]),
      .TCB_BASE  (TCB_BASE[i*ADDR_W +: ADDR_W]),
      .TCB_SIZE  (TCB_SIZE[i*ADDR_W +: ADDR_W]),
      .DMA_ALLOW (DMA_ALLOW[i])
    ) u_check (
      .pc        (bus.pc),
      .data_addr (bus.data_addr),
      .w_en      (bus.w_en),
      .dma_addr  (bus.dma_addr),
      .dma_en    (bus.dma_en),
      .cpu_viol  (cpu_viol[i]),
      .dma_viol  (dma_viol[i])
    );
  end

  assign any_viol = (|cpu_viol) || (|dma_viol);

  // Cause selection: CPU beats DMA, lowest region index wins within a source.
  // Scanning from the highest index down lets the lowest hit overwrite the rest.
  always_comb begin
    // NOTE: every output gets a default up front so no path leaves it unassigned
    // and no latch is inferred.
    win_region = '0;
    win_src    = MP_SRC_CPU;
    win_addr   = bus.data_addr;
    if (!(|cpu_viol)) begin
      for (int i = N_REGIONS - 1; i >= 0; i--) begin
        if (dma_viol[i]) begin
          win_region = MP_REGION_W'(i);
          win_src    = MP_SRC_DMA;
          win_addr   = bus.dma_addr;
        end
      end
    end else begin
      for (int i = N_REGIONS - 1; i >= 0; i--) begin
        if (cpu_viol[i]) begin
          win_region = MP_REGION_W'(i);
        end
      end
    end
  end

  // Monitor FSM with hold counter, registered reset request, cause record and counter.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state         <= MP_KILL;
      hold_cnt      <= HOLD_RELOAD;
      reset_q       <= 1'b1;
      viol_valid_q  <= 1'b0;
      viol_region_q <= '0;
      viol_src_q    <= MP_SRC_CPU;
      viol_addr_q   <= '0;
      viol_count_q  <= '0;
    end else begin
      case (state)
        MP_KILL: begin
          reset_q <= 1'b1;
          if (hold_cnt == '0) begin
            state <= MP_WAIT;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        MP_WAIT: begin
          // A violation coinciding with the handler fetch keeps the core held.
          if ((bus.pc == RESET_HANDLER) && !any_viol) begin
            state   <= MP_RUN;
            reset_q <= 1'b0;
          end else begin
            reset_q <= 1'b1;
          end
        end
        MP_RUN: begin
          if (any_viol) begin
            state        <= MP_KILL;
            hold_cnt     <= HOLD_RELOAD;
            reset_q      <= 1'b1;
            viol_count_q <= mp_sat_inc(viol_count_q);
            // First fault wins until the next rst.
            if (!viol_valid_q) begin
              viol_valid_q  <= 1'b1;
              viol_region_q <= win_region;
              viol_src_q    <= win_src;
              viol_addr_q   <= win_addr;
            end
          end else begin
            reset_q <= 1'b0;
          end
        end
        default: begin
          state    <= MP_KILL;
          hold_cnt <= HOLD_RELOAD;
          reset_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.reset       = reset_q;
  assign bus.viol_valid  = viol_valid_q;
  assign bus.viol_region = viol_region_q;
  assign bus.viol_src    = viol_src_q;
  assign bus.viol_addr   = viol_addr_q;
  assign bus.viol_count  = viol_count_q;

endmodule

// File: tb/tb_memory_protection_mr.sv
// Directed bench for memory_protection_mr with two regions and a 4-cycle hold.
module tb_memory_protection_mr;

  localparam int ADDR_W = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  memory_protection_mr_if #(.ADDR_W(ADDR_W)) bus ();

  memory_protection_mr #(
    .ADDR_W        (ADDR_W),
    .N_REGIONS     (2),
    .REGION_BASE   ({16'h0300, 16'h0200}),
    .REGION_SIZE   ({16'h0010, 16'h0020}),
    .TCB_BASE      ({16'h0000, 16'hA000}),
    .TCB_SIZE      ({16'h0000, 16'h0100}),
    .DMA_ALLOW     (2'b10),
    .RESET_HANDLER (16'h0000),
    .RST_HOLD      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.w_en      = 1'b0;
    bus.dma_en    = 1'b0;
    bus.data_addr = 16'h0000;
    bus.dma_addr  = 16'h0000;
    bus.pc        = 16'h0000;
  endtask

  // Clean bus with pc at the handler until reset drops, bounded.
  task automatic wait_run(input string tag);
    idle_bus();
    for (int k = 0; k < 20; k++) begin
      if (bus.reset === 1'b0) break;
      tick();
    end
    check(tag, 32'(bus.reset), 32'd0);
  endtask

  task automatic check_record(input string tag, input logic valid, input logic [2:0] region,
                              input logic src, input logic [15:0] addr, input logic [7:0] count);
    check({tag, "_valid"},  32'(bus.viol_valid),  32'(valid));
    check({tag, "_region"}, 32'(bus.viol_region), 32'(region));
    check({tag, "_src"},    32'(bus.viol_src),    32'(src));
    check({tag, "_addr"},   32'(bus.viol_addr),   32'(addr));
    check({tag, "_count"},  32'(bus.viol_count),  32'(count));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_bus();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    idle_bus();

    // Reset state.
    tick();
    check("rst_reset", 32'(bus.reset), 32'd1);
    check_record("rst", 1'b0, 3'd0, 1'b0, 16'h0000, 8'h00);
    rst = 1'b0;

    // 1: four KILL cycles (reset edge plus three) and one WAIT cycle, then release.
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("t1_hold%0d", k), 32'(bus.reset), 32'd1);
    end
    tick();
    check("t1_release", 32'(bus.reset), 32'd0);
    check("t1_count", 32'(bus.viol_count), 32'd0);

    // 2: trusted write from inside the TCB, including its last trusted pc.
    bus.pc = 16'hA010; bus.w_en = 1'b1; bus.data_addr = 16'h0210;
    tick();
    check("t2_tcb_ok", 32'(bus.reset), 32'd0);
    bus.pc = 16'hA0FE;
    tick();
    check("t2_tcb_edge", 32'(bus.reset), 32'd0);
    // Just past the region end: no region hit even from an untrusted pc.
    bus.pc = 16'h8000; bus.data_addr = 16'h0220;
    tick();
    check("t2_region_end", 32'(bus.reset), 32'd0);
    bus.pc = 16'hA0FF; bus.data_addr = 16'h0210;
    tick();
    check("t2_tcb_over", 32'(bus.reset), 32'd1);
    check_record("t2", 1'b1, 3'd0, 1'b0, 16'h0210, 8'h01);

    // Clear the record so test 3 sees a first fault.
    do_reset();
    wait_run("t3_recover");

    // 3: simultaneous CPU (region 1) and DMA (region 0) violations: CPU wins.
    bus.pc = 16'h8000; bus.w_en = 1'b1; bus.data_addr = 16'h0305;
    bus.dma_en = 1'b1; bus.dma_addr = 16'h0201;
    tick();
    check("t3_reset", 32'(bus.reset), 32'd1);
    check_record("t3", 1'b1, 3'd1, 1'b0, 16'h0305, 8'h01);
    wait_run("t4_recover");

    // 4: DMA allowed into region 1, forbidden in region 0 at its last byte.
    bus.dma_en = 1'b1; bus.dma_addr = 16'h0308;
    tick();
    check("t4_dma_ok", 32'(bus.reset), 32'd0);
    bus.dma_addr = 16'h021F;
    tick();
    check("t4_dma_viol", 32'(bus.reset), 32'd1);
    check_record("t4", 1'b1, 3'd1, 1'b0, 16'h0305, 8'h02);

    // 5: reach WAIT with pc away from the handler, then a handler fetch plus violation.
    idle_bus();
    bus.pc = 16'h1234;
    for (int k = 0; k < 5; k++) tick();
    check("t5_wait", 32'(bus.reset), 32'd1);
    bus.pc = 16'h0000; bus.w_en = 1'b1; bus.data_addr = 16'h0200;
    tick();
    check("t5_wait_viol", 32'(bus.reset), 32'd1);
    bus.w_en = 1'b0;
    tick();
    check("t5_release", 32'(bus.reset), 32'd0);
    check("t5_count", 32'(bus.viol_count), 32'd2);

    // 6: 260 more violations saturate the counter.
    for (int n = 0; n < 260; n++) begin
      bus.pc = 16'h0000; bus.w_en = 1'b1; bus.data_addr = 16'h0300;
      tick();
      if (n < 259) begin
        for (int k = 0; k < 20; k++) begin
          bus.w_en = 1'b0;
          tick();
          if (bus.reset === 1'b0) break;
        end
      end
    end
    check("t6_in_kill", 32'(bus.reset), 32'd1);
    check_record("t6_sat", 1'b1, 3'd1, 1'b0, 16'h0305, 8'hFF);

    // rst mid-hold clears everything and restarts a full hold.
    bus.w_en = 1'b0;
    tick();
    do_reset();
    check("t6_rst_reset", 32'(bus.reset), 32'd1);
    check_record("t6_rst", 1'b0, 3'd0, 1'b0, 16'h0000, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("t6_hold%0d", k), 32'(bus.reset), 32'd1);
    end
    tick();
    check("t6_release", 32'(bus.reset), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
